pc_sequencer: RTL and testbench

Next-PC controller for the single-issue CPU fetch stage. Every cycle it computes the value presented to the ProgramCounter register input, choosing among sequential increment, branch, jump, jump-register and exception-vector targets. It also handles hazard stalls and instruction-memory wait states, and holds redirects that arrive while fetch is blocked. Its output feeds the PC register directly; the PC register output returns as `pc_cur`.

---
 rtl/pc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// It picks the next PC from sequential, branch, jump, jump-register and exception targets.
// It handles hazard stalls and imem wait states, and holds redirects that arrive while fetch waits.
// Optional build macro: PC_ALIGN_CHECK_EN.
// When PC_ALIGN_CHECK_EN is defined, a misaligned redirect target raises an exception.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic [31:0] pc_next,
  output logic        flush,
  output logic        fetch_valid,
  output logic [31:0] epc
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    EXC  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            redir_valid;
  logic [PC_W-1:0] redir_target;
  logic            align_fault;
  logic            exc_hit;
  logic            pend_valid;
  logic [PC_W-1:0] pend_target;
  logic            eff_valid;
  logic [PC_W-1:0] eff_target;
  logic [PC_W-1:0] pc_inc;

  // Redirect arbitration: jr > jump > branch; exception is handled separately.
  always_comb begin
    redir_valid  = jr | jump | branch_taken;
    redir_target = branch_target;
    if (jr) begin
      redir_target = jr_target;
    end else if (jump) begin
      redir_target = jump_target;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned winning redirect target is promoted to an exception.
  always_comb begin
    align_fault = redir_valid & (redir_target[1:0] != 2'b00);
  end
`else
  assign align_fault = 1'b0;
`endif

  assign exc_hit    = exception | align_fault;
  assign eff_valid  = redir_valid | pend_valid;
  assign eff_target = redir_valid ? redir_target : pend_target;
  assign pc_inc     = pc_cur + PC_W'(4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (exc_hit) begin
          state_nxt = EXC;
        end else if (!imem_ready) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
      WAIT: begin
        if (exc_hit) begin
          state_nxt = EXC;
        end else if (imem_ready) begin
          state_nxt = RUN;
        end else begin
          state_nxt = WAIT;
        end
      end
      EXC: state_nxt = exception ? EXC : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic: next PC, flush and fetch_valid are combinational.
  always_comb begin
    pc_next     = pc_cur;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    if (rst) begin
      pc_next = RESET_VECTOR;
      flush   = 1'b1;
    end else begin
      case (state)
        BOOT: pc_next = pc_cur;
        RUN: begin
          if (exc_hit) begin
            pc_next = EXC_VECTOR;
            flush   = 1'b1;
          end else if (redir_valid && imem_ready) begin
            pc_next = redir_target;
            flush   = 1'b1;
          end else if (!imem_ready) begin
            pc_next = pc_cur;
          end else if (stall) begin
            pc_next     = pc_cur;
            fetch_valid = 1'b1;
          end else begin
            pc_next     = pc_inc;
            fetch_valid = 1'b1;
          end
        end
        WAIT: begin
          if (exc_hit) begin
            pc_next = EXC_VECTOR;
            flush   = 1'b1;
          end else if (imem_ready) begin
            if (eff_valid) begin
              pc_next = eff_target;
              flush   = 1'b1;
            end else if (stall) begin
              pc_next     = pc_cur;
              fetch_valid = 1'b1;
            end else begin
              pc_next     = pc_inc;
              fetch_valid = 1'b1;
            end
          end
        end
        EXC: begin
          pc_next = pc_cur;
          flush   = 1'b1;
        end
        default: pc_next = pc_cur;
      endcase
    end
  end

  // Pending redirect: captured while imem is busy and consumed when it returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!exc_hit && redir_valid && !imem_ready) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
          end else begin
            pend_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (exc_hit || imem_ready) begin
            pend_valid <= 1'b0;
          end else if (redir_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
          end
        end
        default: pend_valid <= 1'b0;
      endcase
    end
  end

  // Exception PC capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= '0;
    end else if (((state == RUN) || (state == WAIT)) && exc_hit) begin
      epc <= pc_cur;
    end else if ((state == EXC) && exception) begin
      epc <= pc_cur;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a behavioural PC register in the loop.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic [31:0] pc_next;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] epc;

  int n_chk  = 0;
  int n_pass = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .exception    (exception),
    .pc_next      (pc_next),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .epc          (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register fed by the sequencer.
  always @(posedge clk) pc_cur <= pc_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [31:0] addr);
    int n = 0;
    while (pc_cur !== addr && n < 200) begin
      tick();
      n++;
    end
    chk("run_to", pc_cur, addr);
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    jump        = 1'b1;
    jump_target = addr;
    tick();
    jump = 1'b0;
    #1;
    chk("reposition", pc_cur, addr);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    jr = 1'b0; jr_target = '0; exception = 1'b0;

    // Reset across two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc_cur", pc_cur, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_flush", 32'(flush), 32'd1);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_epc", epc, 32'h0);

    // BOOT then sequential fetch
    rst = 1'b0; #1;
    chk("boot_pc_next", pc_next, 32'h0);
    chk("boot_fv", 32'(fetch_valid), 32'd0);
    tick();
    chk("run0_fv", 32'(fetch_valid), 32'd1);
    chk("run0_pc_next", pc_next, 32'h4);
    tick(); chk("seq_4", pc_cur, 32'h4);
    tick(); chk("seq_8", pc_cur, 32'h8);
    tick(); chk("seq_12", pc_cur, 32'hC);

    // Stall holds PC at 0x20
    run_to(32'h20);
    stall = 1'b1; #1;
    chk("stall_pc_next", pc_next, 32'h20);
    chk("stall_fv", 32'(fetch_valid), 32'd1);
    tick(); tick(); tick();
    chk("stall_hold", pc_cur, 32'h20);
    stall = 1'b0; #1;
    chk("unstall_pc_next", pc_next, 32'h24);

    // imem wait with jr captured in the first wait cycle
    run_to(32'h30);
    imem_ready = 1'b0; jr = 1'b1; jr_target = 32'h500; #1;
    chk("wait_jr_pc_next", pc_next, 32'h30);
    chk("wait_jr_flush", 32'(flush), 32'd0);
    tick();
    jr = 1'b0; #1;
    chk("wait1_pc", pc_cur, 32'h30);
    chk("wait1_fv", 32'(fetch_valid), 32'd0);
    tick();
    chk("wait2_pc", pc_cur, 32'h30);
    imem_ready = 1'b1; #1;
    chk("pend_pc_next", pc_next, 32'h500);
    chk("pend_flush", 32'(flush), 32'd1);
    tick();
    chk("pend_taken", pc_cur, 32'h500);
    chk("after_pend_next", pc_next, 32'h504);

    // Jump beats branch
    redirect_to(32'h40);
    jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h200; #1;
    chk("prio_pc_next", pc_next, 32'h100);
    chk("prio_flush", 32'(flush), 32'd1);
    tick();
    jump = 1'b0; branch_taken = 1'b0; #1;
    chk("prio_pc", pc_cur, 32'h100);

    // Redirect overrides stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300; #1;
    chk("redir_stall_next", pc_next, 32'h300);
    chk("redir_stall_fv", 32'(fetch_valid), 32'd0);
    tick();
    stall = 1'b0; branch_taken = 1'b0; #1;
    chk("redir_stall_pc", pc_cur, 32'h300);

    // Exception while stalled
    redirect_to(32'h1C);
    stall = 1'b1; exception = 1'b1; #1;
    chk("exc_pc_next", pc_next, 32'h80);
    chk("exc_flush", 32'(flush), 32'd1);
    tick();
    exception = 1'b0; stall = 1'b0; #1;
    chk("exc_epc", epc, 32'h1C);
    chk("exc_pc", pc_cur, 32'h80);
    chk("exc_flush2", 32'(flush), 32'd1);
    chk("exc_fv", 32'(fetch_valid), 32'd0);
    tick();
    chk("post_exc_flush", 32'(flush), 32'd0);
    chk("post_exc_next", pc_next, 32'h84);
    tick();
    chk("post_exc_pc", pc_cur, 32'h84);

    // 32-bit wrap of the increment
    redirect_to(32'hFFFF_FFFC);
    chk("wrap_next", pc_next, 32'h0);
    tick();
    chk("wrap_pc", pc_cur, 32'h0);

    // Misaligned branch target
    redirect_to(32'h50);
    branch_taken = 1'b1; branch_target = 32'h102;
    tick();
    branch_taken = 1'b0; #1;
`ifdef PC_ALIGN_CHECK_EN
    chk("align_epc", epc, 32'h50);
    chk("align_pc", pc_cur, 32'h80);
`else
    chk("align_pc", pc_cur, 32'h102);
`endif
    tick();

    // Exception during an imem wait
    redirect_to(32'h60);
    imem_ready = 1'b0;
    tick();
    exception = 1'b1; #1;
    chk("wait_exc_next", pc_next, 32'h80);
    tick();
    exception = 1'b0; imem_ready = 1'b1; #1;
    chk("wait_exc_epc", epc, 32'h60);
    chk("wait_exc_pc", pc_cur, 32'h80);
    tick();

    // Reset mid-WAIT discards the pending redirect
    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h700;
    tick();
    jump = 1'b0; rst = 1'b1; #1;
    chk("midrst_pc_next", pc_next, 32'h0);
    tick(); tick();
    rst = 1'b0; imem_ready = 1'b1; #1;
    chk("midrst_boot", pc_next, 32'h0);
    tick();
    chk("midrst_no_pend", pc_next, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
